// File: rtl/alu_mdu.sv
// ============================================================================
// Module  : alu_mdu
// Brief   : EX-stage ALU with single-cycle logic/arith and iterative MUL/DIV.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_mdu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [3:0]       ALUctr,
    output logic             out_valid,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] R_hi,
    output logic             Overflow,
    output logic             Zero,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0]    C_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [3:0] OP_ADDU = 4'b0000, OP_ADD = 4'b0001, OP_OR  = 4'b0010,
                           OP_AND  = 4'b0011, OP_SUBU = 4'b0100, OP_SUB = 4'b0101,
                           OP_SLTU = 4'b0110, OP_SLT = 4'b0111, OP_XOR = 4'b1100,
                           OP_NOR  = 4'b1101;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  acc_q, acc_d, lo_q, lo_d, b_q, b_d, x_q, x_d;
    logic              div_q, div_d, sgn_q, sgn_d, qneg_q, qneg_d;
    logic              xneg_q, xneg_d, yneg_q, yneg_d;
    logic [WIDTH-1:0]  r_q, r_d, rhi_q, rhi_d;
    logic              ovf_q, ovf_d, zero_q, zero_d, dz_q, dz_d, ov_q, ov_d;

    // Single-cycle datapath
    logic [WIDTH-1:0] w_add, w_sub, w_sc_r;
    logic             w_sc_ovf, w_reserved, w_is_md;

    assign w_add      = X + Y;
    assign w_sub      = X - Y;
    assign w_reserved = (ALUctr[3:1] == 3'b111);
    assign w_is_md    = (ALUctr[3:2] == 2'b10);

    always_comb begin
        w_sc_r   = '0;
        w_sc_ovf = 1'b0;
        case (ALUctr)
            OP_ADDU: w_sc_r = w_add;
            OP_ADD: begin
                w_sc_r   = w_add;
                w_sc_ovf = (X[WIDTH-1] == Y[WIDTH-1]) && (w_add[WIDTH-1] != X[WIDTH-1]);
            end
            OP_OR:   w_sc_r = X | Y;
            OP_AND:  w_sc_r = X & Y;
            OP_SUBU: w_sc_r = w_sub;
            OP_SUB: begin
                w_sc_r   = w_sub;
                w_sc_ovf = (X[WIDTH-1] != Y[WIDTH-1]) && (w_sub[WIDTH-1] != X[WIDTH-1]);
            end
            OP_SLTU: w_sc_r[0] = (X < Y);
            OP_SLT:  w_sc_r[0] = ($signed(X) < $signed(Y));
            OP_XOR:  w_sc_r = X ^ Y;
            OP_NOR:  w_sc_r = ~(X | Y);
            default: w_sc_r = '0;
        endcase
    end

    // One iteration: shift-add for MUL, restoring shift-subtract for DIV
    logic [WIDTH:0]   w_msum, w_dsh, w_ddiff;
    logic [WIDTH-1:0] w_acc_n, w_lo_n;

    assign w_msum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign w_dsh   = {acc_q, lo_q[WIDTH-1]};
    assign w_ddiff = w_dsh - {1'b0, b_q};

    always_comb begin
        if (!div_q) begin
            w_acc_n = w_msum[WIDTH:1];
            w_lo_n  = {w_msum[0], lo_q[WIDTH-1:1]};
        end else if (w_dsh >= {1'b0, b_q}) begin
            w_acc_n = w_ddiff[WIDTH-1:0];
            w_lo_n  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            w_acc_n = w_dsh[WIDTH-1:0];
            w_lo_n  = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    // Sign correction applied to the final iteration's result
    logic [2*WIDTH-1:0] w_prod_raw, w_prod;
    logic [WIDTH-1:0]   w_fx_r, w_fx_hi;
    logic               w_fx_ovf, w_fx_dz;

    assign w_prod_raw = {w_acc_n, w_lo_n};
    assign w_prod     = qneg_q ? -w_prod_raw : w_prod_raw;

    always_comb begin
        w_fx_r   = '0;
        w_fx_hi  = '0;
        w_fx_ovf = 1'b0;
        w_fx_dz  = 1'b0;
        if (!div_q) begin
            if (sgn_q) begin
                w_fx_r   = w_prod[WIDTH-1:0];
                w_fx_hi  = w_prod[2*WIDTH-1:WIDTH];
                w_fx_ovf = (w_prod[2*WIDTH-1:WIDTH] != {WIDTH{w_prod[WIDTH-1]}});
            end else begin
                w_fx_r   = w_lo_n;
                w_fx_hi  = w_acc_n;
                w_fx_ovf = |w_acc_n;
            end
        end else if (b_q == '0) begin
            w_fx_r  = '1;
            w_fx_hi = x_q;
            w_fx_dz = 1'b1;
        end else begin
            w_fx_r   = qneg_q ? -w_lo_n : w_lo_n;
            w_fx_hi  = xneg_q ? -w_acc_n : w_acc_n;
            w_fx_ovf = yneg_q && (b_q == WIDTH'(1)) && (x_q == C_MIN);
        end
    end

    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        b_d     = b_q;
        x_d     = x_q;
        div_d   = div_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        xneg_d  = xneg_q;
        yneg_d  = yneg_q;
        r_d     = r_q;
        rhi_d   = rhi_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        dz_d    = dz_q;
        ov_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && w_is_md) begin
                    // Iterate on magnitudes; signs are restored in the final step
                    sgn_d   = ALUctr[0];
                    div_d   = ALUctr[1];
                    xneg_d  = ALUctr[0] & X[WIDTH-1];
                    yneg_d  = ALUctr[0] & Y[WIDTH-1];
                    qneg_d  = (ALUctr[0] & X[WIDTH-1]) ^ (ALUctr[0] & Y[WIDTH-1]);
                    x_d     = X;
                    acc_d   = '0;
                    cnt_d   = '0;
                    lo_d    = ALUctr[1] ? ((ALUctr[0] & X[WIDTH-1]) ? -X : X)
                                        : ((ALUctr[0] & Y[WIDTH-1]) ? -Y : Y);
                    b_d     = ALUctr[1] ? ((ALUctr[0] & Y[WIDTH-1]) ? -Y : Y)
                                        : ((ALUctr[0] & X[WIDTH-1]) ? -X : X);
                    state_d = RUN;
                end else if (in_valid) begin
                    r_d    = w_sc_r;
                    rhi_d  = '0;
                    ovf_d  = w_sc_ovf;
                    zero_d = (w_sc_r == '0) && !w_reserved;
                    dz_d   = 1'b0;
                    ov_d   = 1'b1;
                end
            end
            RUN: begin
                acc_d = w_acc_n;
                lo_d  = w_lo_n;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == C_LAST) begin
                    r_d     = w_fx_r;
                    rhi_d   = w_fx_hi;
                    ovf_d   = w_fx_ovf;
                    zero_d  = (w_fx_r == '0);
                    dz_d    = w_fx_dz;
                    ov_d    = 1'b1;
                    state_d = FIX;
                end
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            x_q     <= '0;
            div_q   <= 1'b0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            xneg_q  <= 1'b0;
            yneg_q  <= 1'b0;
            r_q     <= '0;
            rhi_q   <= '0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            x_q     <= x_d;
            div_q   <= div_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            xneg_q  <= xneg_d;
            yneg_q  <= yneg_d;
            r_q     <= r_d;
            rhi_q   <= rhi_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign R         = r_q;
    assign R_hi      = rhi_q;
    assign Overflow  = ovf_q;
    assign Zero      = zero_q;
    assign div_zero  = dz_q;
    assign out_valid = ov_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_mdu.sv
// ============================================================================
// Module  : tb_alu_mdu
// Brief   : Directed self-checking bench for alu_mdu at WIDTH=32.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] X = '0, Y = '0;
    logic [3:0]  ALUctr = '0;
    logic        out_valid;
    logic [31:0] R, R_hi;
    logic        Overflow, Zero, div_zero;

    int n_cmp = 0;
    int n_err = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .ALUctr(ALUctr), .out_valid(out_valid),
        .R(R), .R_hi(R_hi), .Overflow(Overflow), .Zero(Zero), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    // Drives one request from IDLE; lat counts edges until out_valid is seen,
    // lowcnt counts sampled cycles with in_ready low before out_valid.
    task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int lowcnt);
        @(negedge clk);
        ALUctr = op; X = x; Y = y; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        lowcnt = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (!in_ready) lowcnt++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_ov: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b want 1", in_ready); end
        n_cmp++; if ({R, R_hi} !== 64'h0) begin n_err++; $display("FAIL reset_r: got %h/%h want 0/0", R, R_hi); end
        n_cmp++; if ({Overflow, Zero, div_zero} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {Overflow, Zero, div_zero}); end
    endtask

    task automatic test_add;
        int lat, low;
        issue(4'b0001, 32'h7FFFFFFF, 32'h1, lat, low);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_lat: got %0d want 1", lat); end
        n_cmp++; if (R !== 32'h80000000) begin n_err++; $display("FAIL add_r: got %h want 80000000", R); end
        n_cmp++; if ({Overflow, Zero} !== 2'b10) begin n_err++; $display("FAIL add_ovf: got %b want 10", {Overflow, Zero}); end
        issue(4'b0000, 32'h7FFFFFFF, 32'h1, lat, low);
        n_cmp++; if ({R, Overflow} !== {32'h80000000, 1'b0}) begin n_err++; $display("FAIL addu: got %h ovf %b want 80000000 ovf 0", R, Overflow); end
        issue(4'b0101, 32'h80000000, 32'h1, lat, low);
        n_cmp++; if ({R, Overflow} !== {32'h7FFFFFFF, 1'b1}) begin n_err++; $display("FAIL sub_ovf: got %h ovf %b want 7fffffff ovf 1", R, Overflow); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        ALUctr = 4'b0101; X = 32'd5; Y = 32'd5; in_valid = 1'b1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy0: got %b want 1", in_ready); end
        @(negedge clk);
        n_cmp++; if ({out_valid, R, Zero, Overflow} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin n_err++; $display("FAIL b2b_sub: got ov %b R %h Z %b V %b want 1 0 1 0", out_valid, R, Zero, Overflow); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_rdy1: got %b want 1", in_ready); end
        ALUctr = 4'b0111; X = 32'hFFFFFFFF; Y = 32'h1;
        @(negedge clk);
        n_cmp++; if ({out_valid, R, Zero} !== {1'b1, 32'h1, 1'b0}) begin n_err++; $display("FAIL b2b_slt: got ov %b R %h Z %b want 1 1 0", out_valid, R, Zero); end
        ALUctr = 4'b0110;
        @(negedge clk);
        n_cmp++; if ({out_valid, R, Zero} !== {1'b1, 32'h0, 1'b1}) begin n_err++; $display("FAIL b2b_sltu: got ov %b R %h Z %b want 1 0 1", out_valid, R, Zero); end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_pulse: got %b want 0", out_valid); end
    endtask

    task automatic test_logic;
        int lat, low;
        issue(4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00, lat, low);
        n_cmp++; if (R !== 32'h00F0_1200) begin n_err++; $display("FAIL and: got %h want 00f01200", R); end
        issue(4'b0010, 32'hF0F0_1234, 32'h0FF0_FF00, lat, low);
        n_cmp++; if (R !== 32'hFFF0_FF34) begin n_err++; $display("FAIL or: got %h want fff0ff34", R); end
        issue(4'b1100, 32'hF0F0_1234, 32'h0FF0_FF00, lat, low);
        n_cmp++; if (R !== 32'hFF00_ED34) begin n_err++; $display("FAIL xor: got %h want ff00ed34", R); end
        issue(4'b1101, 32'hF0F0_1234, 32'h0FF0_FF00, lat, low);
        n_cmp++; if (R !== 32'h000F_00CB) begin n_err++; $display("FAIL nor: got %h want 000f00cb", R); end
        issue(4'b1110, 32'h1234_5678, 32'h1, lat, low);
        n_cmp++; if ({lat, R, R_hi, Overflow, div_zero} !== {32'd1, 32'h0, 32'h0, 2'b00}) begin n_err++; $display("FAIL reserved: got lat %0d R %h hi %h V %b dz %b want 1 0 0 0 0", lat, R, R_hi, Overflow, div_zero); end
    endtask

    task automatic test_mul;
        int lat, low;
        issue(4'b1001, 32'hFFFFFFFD, 32'd7, lat, low);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mul_lat: got %0d want 33", lat); end
        n_cmp++; if (low !== 32) begin n_err++; $display("FAIL mul_busy: got %0d want 32", low); end
        n_cmp++; if ({R, R_hi, Overflow} !== {32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0}) begin n_err++; $display("FAIL mul: got %h/%h V %b want ffffffeb/ffffffff V 0", R, R_hi, Overflow); end
        issue(4'b1000, 32'h10000, 32'h10000, lat, low);
        n_cmp++; if ({R, R_hi, Overflow, Zero} !== {32'h0, 32'h1, 1'b1, 1'b1}) begin n_err++; $display("FAIL mulu: got %h/%h V %b Z %b want 0/1 V 1 Z 1", R, R_hi, Overflow, Zero); end
        issue(4'b1001, 32'h10000, 32'h10000, lat, low);
        n_cmp++; if ({R, R_hi, Overflow} !== {32'h0, 32'h1, 1'b1}) begin n_err++; $display("FAIL mul_ovf: got %h/%h V %b want 0/1 V 1", R, R_hi, Overflow); end
    endtask

    task automatic test_div;
        int lat, low;
        issue(4'b1011, 32'hFFFFFFF9, 32'd2, lat, low);
        n_cmp++; if ({R, R_hi, Overflow, div_zero} !== {32'hFFFFFFFD, 32'hFFFFFFFF, 2'b00}) begin n_err++; $display("FAIL div: got %h/%h V %b dz %b want fffffffd/ffffffff 0 0", R, R_hi, Overflow, div_zero); end
        issue(4'b1011, 32'h80000000, 32'hFFFFFFFF, lat, low);
        n_cmp++; if ({R, R_hi, Overflow} !== {32'h80000000, 32'h0, 1'b1}) begin n_err++; $display("FAIL div_min: got %h/%h V %b want 80000000/0 V 1", R, R_hi, Overflow); end
        issue(4'b1011, 32'hFFFFFFFB, 32'd0, lat, low);
        n_cmp++; if ({R, R_hi, div_zero} !== {32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1}) begin n_err++; $display("FAIL div_z: got %h/%h dz %b want ffffffff/fffffffb 1", R, R_hi, div_zero); end
        issue(4'b1010, 32'd100, 32'd7, lat, low);
        n_cmp++; if ({R, R_hi, div_zero} !== {32'd14, 32'd2, 1'b0}) begin n_err++; $display("FAIL divu: got %h/%h dz %b want e/2 0", R, R_hi, div_zero); end
        issue(4'b1010, 32'd7, 32'd0, lat, low);
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divu_z_lat: got %0d want 33", lat); end
        n_cmp++; if ({R, R_hi, div_zero, Overflow} !== {32'hFFFFFFFF, 32'd7, 1'b1, 1'b0}) begin n_err++; $display("FAIL divu_z: got %h/%h dz %b V %b want ffffffff/7 1 0", R, R_hi, div_zero, Overflow); end
    endtask

    task automatic test_reset_abort;
        int lat, low, stray;
        @(negedge clk);
        ALUctr = 4'b1001; X = 32'd6; Y = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if ({out_valid, R, R_hi, Overflow, Zero, div_zero} !== 69'h0) begin n_err++; $display("FAIL abort_out: got ov %b R %h hi %h flags %b want all 0", out_valid, R, R_hi, {Overflow, Zero, div_zero}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_rdy: got %b want 1", in_ready); end
        issue(4'b0001, 32'd2, 32'd3, lat, low);
        n_cmp++; if ({lat, R} !== {32'd1, 32'd5}) begin n_err++; $display("FAIL abort_add: got lat %0d R %h want 1 5", lat, R); end
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        n_cmp++; if (stray !== 0) begin n_err++; $display("FAIL abort_stray: got %0d pulses want 0", stray); end
    endtask

    task automatic test_hold;
        int lat, busy_bad;
        @(negedge clk);
        ALUctr = 4'b1001; X = 32'd6; Y = 32'd7; in_valid = 1'b1;
        @(posedge clk);
        #1 ALUctr = 4'b0001; X = 32'd1; Y = 32'd2;
        lat = 0;
        busy_bad = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (in_ready) busy_bad++;
        end
        n_cmp++; if ({lat, busy_bad} !== {32'd33, 32'd0}) begin n_err++; $display("FAIL hold_mul: got lat %0d early-ready %0d want 33 0", lat, busy_bad); end
        n_cmp++; if (R !== 32'd42) begin n_err++; $display("FAIL hold_mul_r: got %h want 2a", R); end
        @(negedge clk);
        n_cmp++; if ({out_valid, in_ready, R} !== {1'b0, 1'b1, 32'd42}) begin n_err++; $display("FAIL hold_gap: got ov %b rdy %b R %h want 0 1 2a", out_valid, in_ready, R); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({out_valid, R} !== {1'b1, 32'd3}) begin n_err++; $display("FAIL hold_add: got ov %b R %h want 1 3", out_valid, R); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_pulse: got %b want 0", out_valid); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        test_reset();
        test_add();
        test_back_to_back();
        test_logic();
        test_mul();
        test_div();
        test_reset_abort();
        test_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
